// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : LA32R-style memory-access stage between execute and writeback;
//             drives an SRAM-like req/addr_ok/data_ok bus for loads/stores.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_allowin_o,
    input  logic [4:0]        ex_reg_write_addr_i,
    input  logic              ex_reg_write_en_i,
    input  logic [DATA_W-1:0] ex_reg_write_data_i,
    input  logic [3:0]        ex_mem_op_i,
    input  logic [DATA_W-1:0] ex_store_data_i,
    output logic              wb_valid_o,
    input  logic              wb_allowin_i,
    output logic [4:0]        wb_reg_write_addr_o,
    output logic              wb_reg_write_en_o,
    output logic [DATA_W-1:0] wb_reg_write_data_o,
    output logic              wb_ale_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [3:0]        data_wstrb_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i
);

    localparam logic [3:0] c_OP_NONE  = 4'd0;
    localparam logic [3:0] c_OP_LD_B  = 4'd1;
    localparam logic [3:0] c_OP_LD_H  = 4'd2;
    localparam logic [3:0] c_OP_LD_W  = 4'd3;
    localparam logic [3:0] c_OP_LD_BU = 4'd4;
    localparam logic [3:0] c_OP_LD_HU = 4'd5;
    localparam logic [3:0] c_OP_ST_B  = 4'd6;
    localparam logic [3:0] c_OP_ST_H  = 4'd7;
    localparam logic [3:0] c_OP_ST_W  = 4'd8;

    typedef enum logic [2:0] {
        S_EMPTY   = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_DONE    = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         wr_addr_q;
    logic               wr_en_q;
    logic [DATA_W-1:0]  data_q;
    logic [3:0]         op_q;
    logic               ale_q;
    logic [DATA_W-1:0]  sdata_q;

    logic [3:0]         w_ex_op;
    logic               w_ex_store;
    logic               w_ex_misal;
    logic               w_capture;
    state_t             w_cap_state;
    logic               w_q_load;
    logic               w_q_store;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [DATA_W-1:0]  w_load_data;

    // Undefined op codes behave exactly like "none".
    assign w_ex_op    = (ex_mem_op_i > c_OP_ST_W) ? c_OP_NONE : ex_mem_op_i;
    assign w_ex_store = (w_ex_op >= c_OP_ST_B);
    assign w_ex_misal = (((w_ex_op == c_OP_LD_H) || (w_ex_op == c_OP_LD_HU) || (w_ex_op == c_OP_ST_H))
                            && ex_reg_write_data_i[0])
                      || (((w_ex_op == c_OP_LD_W) || (w_ex_op == c_OP_ST_W))
                            && (ex_reg_write_data_i[1:0] != 2'b00));
    assign w_cap_state = ((w_ex_op != c_OP_NONE) && !w_ex_misal) ? S_REQ : S_DONE;

    assign ex_allowin_o = ((state_q == S_EMPTY) || ((state_q == S_DONE) && wb_allowin_i)) && !flush_i;
    assign w_capture    = ex_valid_i && ex_allowin_o;

    assign w_q_load  = (op_q >= c_OP_LD_B) && (op_q <= c_OP_LD_HU);
    assign w_q_store = (op_q >= c_OP_ST_B) && (op_q <= c_OP_ST_W);

    always_comb begin
        w_byte = data_rdata_i[7:0];
        case (data_q[1:0])
            2'd1:    w_byte = data_rdata_i[15:8];
            2'd2:    w_byte = data_rdata_i[23:16];
            2'd3:    w_byte = data_rdata_i[31:24];
            default: w_byte = data_rdata_i[7:0];
        endcase
        w_half = data_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (op_q)
            c_OP_LD_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_OP_LD_BU: w_load_data = {24'd0, w_byte};
            c_OP_LD_H:  w_load_data = {{16{w_half[15]}}, w_half};
            c_OP_LD_HU: w_load_data = {16'd0, w_half};
            default:    w_load_data = data_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_addr_o  = '0;
        data_wstrb_o = 4'b0000;
        data_wdata_o = '0;
        case (state_q)
            S_EMPTY: begin
                if (w_capture) state_d = w_cap_state;
            end
            S_REQ: begin
                data_req_o  = 1'b1;
                data_we_o   = w_q_store;
                data_addr_o = {data_q[ADDR_W-1:2], 2'b00};
                case (op_q)
                    c_OP_ST_B: begin
                        data_wstrb_o = 4'b0001 << data_q[1:0];
                        data_wdata_o = {4{sdata_q[7:0]}};
                    end
                    c_OP_ST_H: begin
                        data_wstrb_o = 4'b0011 << data_q[1:0];
                        data_wdata_o = {2{sdata_q[15:0]}};
                    end
                    c_OP_ST_W: begin
                        data_wstrb_o = 4'b1111;
                        data_wdata_o = sdata_q;
                    end
                    default: begin
                        data_wstrb_o = 4'b0000;
                        data_wdata_o = '0;
                    end
                endcase
                if (flush_i)             state_d = data_addr_ok_i ? S_DISCARD : S_EMPTY;
                else if (data_addr_ok_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (data_data_ok_i) state_d = flush_i ? S_EMPTY : S_DONE;
                else if (flush_i)   state_d = S_DISCARD;
            end
            S_DONE: begin
                if (flush_i)           state_d = S_EMPTY;
                else if (wb_allowin_i) state_d = w_capture ? w_cap_state : S_EMPTY;
            end
            S_DISCARD: begin
                if (data_data_ok_i) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q <= 5'd0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            op_q      <= 4'd0;
            ale_q     <= 1'b0;
            sdata_q   <= '0;
        end else if (w_capture) begin
            wr_addr_q <= ex_reg_write_addr_i;
            wr_en_q   <= ex_reg_write_en_i && !w_ex_store && !w_ex_misal;
            data_q    <= ex_reg_write_data_i;
            op_q      <= w_ex_op;
            ale_q     <= w_ex_misal;
            sdata_q   <= ex_store_data_i;
        end else if ((state_q == S_WAIT) && data_data_ok_i && !flush_i && w_q_load) begin
            data_q    <= w_load_data;
        end
    end

    assign wb_valid_o          = (state_q == S_DONE);
    assign wb_reg_write_addr_o = wr_addr_q;
    assign wb_reg_write_en_o   = wr_en_q;
    assign wb_reg_write_data_o = data_q;
    assign wb_ale_o            = ale_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : directed self-checking bench for mem_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        ex_valid_i;
    logic        ex_allowin_o;
    logic [4:0]  ex_reg_write_addr_i;
    logic        ex_reg_write_en_i;
    logic [31:0] ex_reg_write_data_i;
    logic [3:0]  ex_mem_op_i;
    logic [31:0] ex_store_data_i;
    logic        wb_valid_o;
    logic        wb_allowin_i;
    logic [4:0]  wb_reg_write_addr_o;
    logic        wb_reg_write_en_o;
    logic [31:0] wb_reg_write_data_o;
    logic        wb_ale_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush_i),
        .ex_valid_i          (ex_valid_i),
        .ex_allowin_o        (ex_allowin_o),
        .ex_reg_write_addr_i (ex_reg_write_addr_i),
        .ex_reg_write_en_i   (ex_reg_write_en_i),
        .ex_reg_write_data_i (ex_reg_write_data_i),
        .ex_mem_op_i         (ex_mem_op_i),
        .ex_store_data_i     (ex_store_data_i),
        .wb_valid_o          (wb_valid_o),
        .wb_allowin_i        (wb_allowin_i),
        .wb_reg_write_addr_o (wb_reg_write_addr_o),
        .wb_reg_write_en_o   (wb_reg_write_en_o),
        .wb_reg_write_data_o (wb_reg_write_data_o),
        .wb_ale_o            (wb_ale_o),
        .data_req_o          (data_req_o),
        .data_we_o           (data_we_o),
        .data_addr_o         (data_addr_o),
        .data_wstrb_o        (data_wstrb_o),
        .data_wdata_o        (data_wdata_o),
        .data_addr_ok_i      (data_addr_ok_i),
        .data_data_ok_i      (data_data_ok_i),
        .data_rdata_i        (data_rdata_i)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1; checks run at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] a, input logic [31:0] d, input logic [3:0] op,
                           input logic [31:0] sd);
        ex_valid_i          = 1'b1;
        ex_reg_write_addr_i = a;
        ex_reg_write_en_i   = 1'b1;
        ex_reg_write_data_i = d;
        ex_mem_op_i         = op;
        ex_store_data_i     = sd;
    endtask

    task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp, input int waitcyc);
        present(5'd7, addr, op, 32'h0);
        tick();
        ex_valid_i     = 1'b0;
        data_addr_ok_i = 1'b1;
        #1;
        check_val({tag, "_req"},   {31'd0, data_req_o}, 32'd1);
        check_val({tag, "_addr"},  data_addr_o, {addr[31:2], 2'b00});
        check_val({tag, "_wstrb"}, {28'd0, data_wstrb_o}, 32'd0);
        tick();
        data_addr_ok_i = 1'b0;
        for (int i = 0; i < waitcyc; i++) begin
            #1;
            check_val({tag, "_wait_req"}, {31'd0, data_req_o}, 32'd0);
            tick();
        end
        data_data_ok_i = 1'b1;
        data_rdata_i   = rdata;
        #1;
        check_val({tag, "_wbv_early"}, {31'd0, wb_valid_o}, 32'd0);
        tick();
        data_data_ok_i = 1'b0;
        data_rdata_i   = 32'h0;
        #1;
        check_val({tag, "_wbv"},  {31'd0, wb_valid_o}, 32'd1);
        check_val({tag, "_data"}, wb_reg_write_data_o, exp);
        check_val({tag, "_en"},   {31'd0, wb_reg_write_en_o}, 32'd1);
        tick();
    endtask

    task automatic do_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [3:0] strb,
                            input logic [31:0] wdata, input int stall);
        present(5'd3, addr, op, sd);
        tick();
        ex_valid_i = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            data_addr_ok_i = (i == stall);
            #1;
            check_val({tag, "_req"},   {31'd0, data_req_o}, 32'd1);
            check_val({tag, "_we"},    {31'd0, data_we_o}, 32'd1);
            check_val({tag, "_addr"},  data_addr_o, {addr[31:2], 2'b00});
            check_val({tag, "_wstrb"}, {28'd0, data_wstrb_o}, {28'd0, strb});
            check_val({tag, "_wdata"}, data_wdata_o, wdata);
            tick();
        end
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b1;
        tick();
        data_data_ok_i = 1'b0;
        #1;
        check_val({tag, "_wbv"},  {31'd0, wb_valid_o}, 32'd1);
        check_val({tag, "_en"},   {31'd0, wb_reg_write_en_o}, 32'd0);
        check_val({tag, "_data"}, wb_reg_write_data_o, addr);
        tick();
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; ex_valid_i = 1'b0; ex_reg_write_addr_i = 5'd0;
        ex_reg_write_en_i = 1'b0; ex_reg_write_data_i = 32'h0; ex_mem_op_i = 4'd0;
        ex_store_data_i = 32'h0; wb_allowin_i = 1'b1; data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_val("rst_wbv",     {31'd0, wb_valid_o}, 32'd0);
        check_val("rst_wbdata",  wb_reg_write_data_o, 32'd0);
        check_val("rst_req",     {31'd0, data_req_o}, 32'd0);
        check_val("rst_allowin", {31'd0, ex_allowin_o}, 32'd1);

        // ALU passthrough
        present(5'd5, 32'h0000_1234, 4'd0, 32'h0);
        tick();
        ex_valid_i = 1'b0;
        #1;
        check_val("alu_wbv",  {31'd0, wb_valid_o}, 32'd1);
        check_val("alu_addr", {27'd0, wb_reg_write_addr_o}, 32'd5);
        check_val("alu_data", wb_reg_write_data_o, 32'h0000_1234);
        check_val("alu_ale",  {31'd0, wb_ale_o}, 32'd0);
        check_val("alu_req",  {31'd0, data_req_o}, 32'd0);
        tick();
        check_val("alu_empty", {31'd0, wb_valid_o}, 32'd0);

        // Loads
        do_load("ldb",  4'd1, 32'h1000_0003, 32'h80FF_FF7F, 32'hFFFF_FF80, 1);
        do_load("ldbu", 4'd4, 32'h1000_0003, 32'h80FF_FF7F, 32'h0000_0080, 1);
        do_load("ldh",  4'd2, 32'h0000_0202, 32'h8001_1234, 32'hFFFF_8001, 2);
        do_load("ldhu", 4'd5, 32'h0000_0202, 32'h8001_1234, 32'h0000_8001, 0);
        do_load("ldw",  4'd3, 32'h0000_0204, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);

        // Stores
        do_store("sth", 4'd7, 32'h2000_0002, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF, 3);
        do_store("stb", 4'd6, 32'h0000_0061, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5, 0);
        do_store("stw", 4'd8, 32'h0000_0100, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 1);

        // Misaligned LD_W: no bus access, ale set, write disabled
        present(5'd9, 32'h3000_0001, 4'd3, 32'h0);
        tick();
        ex_valid_i = 1'b0;
        #1;
        check_val("ale_req", {31'd0, data_req_o}, 32'd0);
        check_val("ale_wbv", {31'd0, wb_valid_o}, 32'd1);
        check_val("ale_flag", {31'd0, wb_ale_o}, 32'd1);
        check_val("ale_en",  {31'd0, wb_reg_write_en_o}, 32'd0);
        tick();

        // Backpressure then bubble-free back-to-back capture
        present(5'd9, 32'h0000_CAFE, 4'd0, 32'h0);
        tick();
        present(5'd10, 32'h0000_D00D, 4'd0, 32'h0);
        wb_allowin_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("bp_wbv",     {31'd0, wb_valid_o}, 32'd1);
            check_val("bp_data",    wb_reg_write_data_o, 32'h0000_CAFE);
            check_val("bp_addr",    {27'd0, wb_reg_write_addr_o}, 32'd9);
            check_val("bp_allowin", {31'd0, ex_allowin_o}, 32'd0);
            tick();
        end
        wb_allowin_i = 1'b1;
        #1;
        check_val("bp_rel_allowin", {31'd0, ex_allowin_o}, 32'd1);
        tick();
        ex_valid_i = 1'b0;
        #1;
        check_val("b2b_wbv",  {31'd0, wb_valid_o}, 32'd1);
        check_val("b2b_data", wb_reg_write_data_o, 32'h0000_D00D);
        check_val("b2b_addr", {27'd0, wb_reg_write_addr_o}, 32'd10);
        tick();
        check_val("b2b_empty", {31'd0, wb_valid_o}, 32'd0);

        // Flush in WAIT: response arrives 3 cycles later and is dropped
        present(5'd4, 32'h4000_0000, 4'd3, 32'h0);
        tick();
        ex_valid_i = 1'b0;
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        flush_i = 1'b1;
        #1;
        check_val("fw_allowin_flush", {31'd0, ex_allowin_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        present(5'd12, 32'h0000_0077, 4'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            data_data_ok_i = (i == 2);
            if (i == 2) ex_valid_i = 1'b0;
            #1;
            check_val("fw_allowin", {31'd0, ex_allowin_o}, 32'd0);
            check_val("fw_wbv",     {31'd0, wb_valid_o}, 32'd0);
            check_val("fw_req",     {31'd0, data_req_o}, 32'd0);
            tick();
        end
        data_data_ok_i = 1'b0;
        #1;
        check_val("fw_empty_allowin", {31'd0, ex_allowin_o}, 32'd1);
        check_val("fw_empty_wbv",     {31'd0, wb_valid_o}, 32'd0);
        tick();
        check_val("fw_no_wb", {31'd0, wb_valid_o}, 32'd0);

        // Flush in REQ without addr_ok: request withdrawn
        present(5'd4, 32'h5000_0000, 4'd3, 32'h0);
        tick();
        ex_valid_i = 1'b0;
        flush_i = 1'b1;
        #1;
        check_val("fr_req", {31'd0, data_req_o}, 32'd1);
        check_val("fr_allowin", {31'd0, ex_allowin_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        #1;
        check_val("fr_req_drop", {31'd0, data_req_o}, 32'd0);
        check_val("fr_wbv",      {31'd0, wb_valid_o}, 32'd0);
        check_val("fr_allowin2", {31'd0, ex_allowin_o}, 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
